// File: rtl/wb_master_standard.sv
// wb_master_standard: command stream to Wishbone classic master, 2-deep command buffer.
// Latency: command accepted at edge N drives the bus from edge N+1; response pulse follows the ack edge.
// Backpressure: cmd_ready = buffer not full (registered); no backpressure on rsp_valid.
//
// Ports:
//   clk, rst_n                 clock, asynchronous active-low reset
//   cmd_valid/cmd_ready        command handshake; cmd_we, cmd_adr, cmd_dat carry the command
//   rsp_valid                  one-cycle pulse per accepted command, in order
//   rsp_we, rsp_dat, rsp_err   command type echo, read data (0 for writes/errors), timeout flag
//   wb_*                       Wishbone classic master signals
//
// Optional feature: define WB_MASTER_TIMEOUT_EN to abort transfers whose ack does not
// arrive within TIMEOUT strobe cycles (rsp_err=1). Without it the master waits forever
// and rsp_err is always 0.

// Small generic FIFO. Head entry is visible combinationally on head_dat.
// Latency: pushed data is visible at the head one cycle after the push edge (when empty).
// Backpressure: caller must not push when full nor pop when empty.
module wbm_fifo #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 2
) (
    input  logic                         clk,
    input  logic                         rst_n,
    input  logic                         push,
    input  logic [WIDTH-1:0]             push_dat,
    input  logic                         pop,
    output logic [WIDTH-1:0]             head_dat,
    output logic [$clog2(DEPTH+1)-1:0]   count,
    output logic                         full,
    output logic                         empty
);
    localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CW = $clog2(DEPTH + 1);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [PW-1:0]    wr_ptr;
    logic [PW-1:0]    rd_ptr;

    function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
        return (p == PW'(DEPTH - 1)) ? '0 : p + 1'b1;
    endfunction

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) wr_ptr <= ptr_inc(wr_ptr);
            if (pop)  rd_ptr <= ptr_inc(rd_ptr);
            count <= count + CW'(push) - CW'(pop);
        end
    end

    // Storage needs no reset: an entry is only read after it has been written.
    always_ff @(posedge clk) begin
        if (push) mem[wr_ptr] <= push_dat;
    end

    assign head_dat = mem[rd_ptr];
    assign full     = (count == CW'(DEPTH));
    assign empty    = (count == '0);
endmodule

module wb_master_standard #(
    parameter int ADR_WIDTH = 16,
    parameter int DAT_WIDTH = 16,
    parameter int TIMEOUT   = 16
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 cmd_valid,
    output logic                 cmd_ready,
    input  logic                 cmd_we,
    input  logic [ADR_WIDTH-1:0] cmd_adr,
    input  logic [DAT_WIDTH-1:0] cmd_dat,
    output logic                 rsp_valid,
    output logic                 rsp_we,
    output logic [DAT_WIDTH-1:0] rsp_dat,
    output logic                 rsp_err,
    output logic                 wb_cyc_o,
    output logic                 wb_stb_o,
    output logic                 wb_we_o,
    output logic [ADR_WIDTH-1:0] wb_adr_o,
    output logic [DAT_WIDTH-1:0] wb_dat_o,
    input  logic [DAT_WIDTH-1:0] wb_dat_i,
    input  logic                 wb_ack_i
);
    typedef struct packed {
        logic                 we;
        logic [ADR_WIDTH-1:0] adr;
        logic [DAT_WIDTH-1:0] dat;
    } cmd_t;

    localparam logic [0:0] ST_IDLE = 1'b0;
    localparam logic [0:0] ST_BUS  = 1'b1;

    logic [0:0] state;
    cmd_t       cmd_in;
    cmd_t       head;
    logic [1:0] fifo_count;
    logic       fifo_full;
    logic       fifo_empty;
    logic       push;
    logic       in_bus;
    logic       ack_hit;
    logic       tmo_expire;
    logic       done;
    logic       more;

    always_comb begin
        cmd_in     = '0;
        cmd_in.we  = cmd_we;
        cmd_in.adr = cmd_adr;
        cmd_in.dat = cmd_dat;
    end

    // cmd_ready depends only on the registered count, never on wb_ack_i.
    assign cmd_ready = !fifo_full;
    assign push      = cmd_valid && cmd_ready;
    assign in_bus    = (state == ST_BUS);
    assign ack_hit   = in_bus && wb_ack_i;
    assign done      = ack_hit || tmo_expire;

    // After the pop another command is available if one was already queued behind
    // the head, or one is being pushed on this same edge; either keeps cyc high.
    assign more = (fifo_count > 2'd1) || push;

    wbm_fifo #(
        .WIDTH ($bits(cmd_t)),
        .DEPTH (2)
    ) u_fifo (
        .clk      (clk),
        .rst_n    (rst_n),
        .push     (push),
        .push_dat (cmd_in),
        .pop      (done),
        .head_dat (head),
        .count    (fifo_count),
        .full     (fifo_full),
        .empty    (fifo_empty)
    );

`ifdef WB_MASTER_TIMEOUT_EN
    localparam int TW = $clog2(TIMEOUT + 1);
    logic [TW-1:0] tmo_cnt;

    // Counts strobe cycles without ack; restarts at zero for every new strobe,
    // so the strobe stays high for exactly TIMEOUT cycles before being dropped.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            tmo_cnt <= '0;
        end else if (!in_bus || done) begin
            tmo_cnt <= '0;
        end else begin
            tmo_cnt <= tmo_cnt + 1'b1;
        end
    end

    // An ack on the expiry edge takes priority and yields a normal response.
    assign tmo_expire = in_bus && !wb_ack_i && (tmo_cnt == TW'(TIMEOUT - 1));
`else
    logic unused_timeout;
    assign unused_timeout = ^TIMEOUT;
    assign tmo_expire     = 1'b0;
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= ST_IDLE;
        end else begin
            case (state)
                ST_IDLE: if (!fifo_empty)     state <= ST_BUS;
                ST_BUS:  if (done && !more)   state <= ST_IDLE;
                default:                      state <= ST_IDLE;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rsp_valid <= 1'b0;
            rsp_we    <= 1'b0;
            rsp_dat   <= '0;
            rsp_err   <= 1'b0;
        end else begin
            rsp_valid <= done;
            if (ack_hit) begin
                rsp_we  <= head.we;
                rsp_dat <= head.we ? '0 : wb_dat_i;
                rsp_err <= 1'b0;
            end else if (tmo_expire) begin
                rsp_we  <= head.we;
                rsp_dat <= '0;
                rsp_err <= 1'b1;
            end else begin
                rsp_we  <= 1'b0;
                rsp_dat <= '0;
                rsp_err <= 1'b0;
            end
        end
    end

    // Bus outputs come straight from the FIFO head. The head only moves on a pop,
    // which ends the strobe, so address/data stay stable for the whole strobe.
    assign wb_cyc_o = in_bus;
    assign wb_stb_o = in_bus;
    assign wb_we_o  = in_bus && head.we;
    assign wb_adr_o = in_bus ? head.adr : '0;
    assign wb_dat_o = (in_bus && head.we) ? head.dat : '0;
endmodule
